if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-002 Parameter INST_NOP, default 16'h0800: instruction driven when no valid fetch exists.
REQ-003 clk_50MHz  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 pc_pause  input  1  1 = downstream stage stalled; hold current fetch result and PC.
REQ-006 branch_en  input  1  single-cycle redirect request.
REQ-007 branch_target  input  16  redirect PC, sampled when branch_en=1.
REQ-008 ram_ready  input  1  instruction RAM read-data-valid strobe.
REQ-009 ram_data  input  16  instruction RAM read data, valid when ram_ready=1.
REQ-010 ram_rd_en  output  1  instruction read request to RAM.
REQ-011 ram_addr  output  16  instruction read address, equal to the PC.
REQ-012 fetch_inst  output  16  fetched instruction to the IF/ID pipeline register.
REQ-013 pc_add_value  output  16  address of fetch_inst plus 1, to the IF/ID pipeline register.
REQ-014 fetch_valid  output  1  fetch_inst/pc_add_value hold a valid fetch.
REQ-015 pc_clear  output  1  one-cycle pulse commanding IF/ID to load a bubble.

Function
REQ-016 States: IDLE, REQ, HOLD, FLUSH; all outputs registered.
REQ-017 IDLE: ram_rd_en=0; unconditional transition to REQ on the next edge.
REQ-018 REQ: ram_rd_en=1, ram_addr=PC; RAM may take any number of cycles to assert ram_ready.
REQ-019 REQ with ram_ready=1 and no branch: fetch_inst<=ram_data, pc_add_value<=PC+1, fetch_valid<=1, PC<=PC+1.
REQ-020 After a capture with pc_pause=0: remain in REQ (back-to-back fetch, one instruction per cycle at zero wait states).
REQ-021 After a capture with pc_pause=1: go to HOLD; ram_rd_en=0.
REQ-022 While pc_pause=1: fetch_inst, pc_add_value and fetch_valid frozen; no new capture; PC frozen.
REQ-023 HOLD: return to REQ on the first cycle pc_pause=0.
REQ-024 REQ with ram_ready=0 and pc_pause=1: keep requesting; the capture is taken when ram_ready arrives, and the pause then applies as in REQ-021.
REQ-025 branch_en=1 has priority over pc_pause and over ram_ready: PC<=branch_target, pc_clear<=1 for exactly one cycle, fetch_valid<=0, fetch_inst<=INST_NOP.
REQ-026 Branch in REQ with ram_ready=0 (read outstanding): go to FLUSH.
REQ-027 FLUSH: ram_rd_en held at 1 on the old address until ram_ready=1; that data is discarded; then go to REQ at branch_target.
REQ-028 Branch in REQ with ram_ready=1 in the same cycle: data discarded; go to REQ at branch_target.
REQ-029 Branch in HOLD: go to REQ at branch_target.
REQ-030 Branch in IDLE: go to REQ at branch_target.
REQ-031 Branch in FLUSH: update the target only; remain in FLUSH.
REQ-032 PC arithmetic: modulo 2^16; 16'hFFFF+1 = 16'h0000; pc_add_value wraps identically.

Reset
REQ-033 rst=0 forces immediately, regardless of state or an outstanding read: state=IDLE, PC=RESET_PC, ram_addr=RESET_PC, ram_rd_en=0, fetch_inst=INST_NOP, pc_add_value=RESET_PC, fetch_valid=0, pc_clear=0.
REQ-034 A RAM response arriving during or after reset, before the first post-reset request, is ignored.

Configuration
REQ-035 Macro FETCH_TIMEOUT_EN: when defined, an 8-bit wait counter tracks REQ/FLUSH cycles with ram_rd_en=1 and ram_ready=0; the counter clears on ram_ready, on a branch, and on reset.
REQ-036 With FETCH_TIMEOUT_EN defined: when the wait counter reaches 255, the block behaves as if ram_ready=1 with ram_data=INST_NOP, and a 1-bit output fetch_err pulses high for one cycle.
REQ-037 Without FETCH_TIMEOUT_EN: no counter and no fetch_err port; the block waits indefinitely for ram_ready.

Verification
REQ-038 Reset release; ram_ready tied 1; ram_data=addr^16'hA5A5 -> fetch_inst sequence 16'hA5A5, 16'hA5A4, ...; pc_add_value 1, 2, 3, ...; one instruction per cycle.
REQ-039 pc_pause=1 for 3 cycles after fetch at PC=4 -> fetch_inst/pc_add_value=5 frozen, ram_rd_en=0; fetch resumes at PC=5.
REQ-040 ram_ready delayed 4 cycles, branch_en with target 16'h0100 in cycle 2 -> pc_clear pulses once, late data discarded, next ram_addr=16'h0100.
REQ-041 PC=16'hFFFF fetch -> pc_add_value=16'h0000, next ram_addr=16'h0000.
REQ-042 rst=0 asserted mid-read at PC=16'h0010 -> ram_rd_en=0 asynchronously; after release, first ram_addr=RESET_PC.
REQ-043 FETCH_TIMEOUT_EN defined, ram_ready held 0 -> after 255 wait cycles fetch_inst=16'h0800, fetch_err pulses, PC advances by 1.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, RAM read handshake, stall/branch/flush control.
// Optional FETCH_TIMEOUT_EN adds a RAM wait timeout with a fetch_err pulse.
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] INST_NOP = 16'h0800
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        pc_pause,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  input  logic        ram_ready,
  input  logic [15:0] ram_data,
  output logic        ram_rd_en,
  output logic [15:0] ram_addr,
  output logic [15:0] fetch_inst,
  output logic [15:0] pc_add_value,
  output logic        fetch_valid,
`ifdef FETCH_TIMEOUT_EN
  output logic        pc_clear,
  output logic        fetch_err
`else
  output logic        pc_clear
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d, addr_d, inst_d, add_d;
  logic        rd_d, valid_d, clear_d;
  logic        rdy;
  logic [15:0] rdata;
  logic        waiting;

  assign waiting = (state == REQ || state == FLUSH) && ram_rd_en;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt, wait_d;
  logic       timeout, err_d;

  // A saturated wait counter stands in for a RAM response carrying a NOP.
  assign timeout = waiting && !ram_ready && (wait_cnt == 8'hFF);
  assign rdy     = ram_ready || timeout;
  assign rdata   = ram_ready ? ram_data : INST_NOP;
  assign err_d   = timeout && !branch_en;

  always_comb begin
    wait_d = 8'h00;
    if (waiting && !rdy && !branch_en)
      wait_d = wait_cnt + 8'h01;
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 8'h00;
      fetch_err <= 1'b0;
    end else begin
      wait_cnt  <= wait_d;
      fetch_err <= err_d;
    end
  end
`else
  assign rdy   = ram_ready;
  assign rdata = ram_data;
`endif

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    addr_d  = ram_addr;
    rd_d    = ram_rd_en;
    inst_d  = fetch_inst;
    add_d   = pc_add_value;
    valid_d = fetch_valid;
    clear_d = 1'b0;
    if (branch_en) begin
      pc_d    = branch_target;
      clear_d = 1'b1;
      valid_d = 1'b0;
      inst_d  = INST_NOP;
      case (state)
        FLUSH: state_d = FLUSH;
        REQ: begin
          // An outstanding read must drain on its old address before redirecting.
          if (!rdy) begin
            state_d = FLUSH;
          end else begin
            state_d = REQ;
            addr_d  = branch_target;
            rd_d    = 1'b1;
          end
        end
        default: begin
          state_d = REQ;
          addr_d  = branch_target;
          rd_d    = 1'b1;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state_d = REQ;
          addr_d  = pc;
          rd_d    = 1'b1;
        end
        REQ: begin
          if (rdy) begin
            inst_d  = rdata;
            add_d   = pc + 16'h0001;
            valid_d = 1'b1;
            pc_d    = pc + 16'h0001;
            addr_d  = pc + 16'h0001;
            if (pc_pause) begin
              state_d = HOLD;
              rd_d    = 1'b0;
            end
          end else if (!pc_pause) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
          end
        end
        HOLD: begin
          if (!pc_pause) begin
            state_d = REQ;
            addr_d  = pc;
            rd_d    = 1'b1;
          end
        end
        FLUSH: begin
          if (rdy) begin
            state_d = REQ;
            addr_d  = pc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      ram_addr     <= RESET_PC;
      ram_rd_en    <= 1'b0;
      fetch_inst   <= INST_NOP;
      pc_add_value <= RESET_PC;
      fetch_valid  <= 1'b0;
      pc_clear     <= 1'b0;
    end else begin
      pc           <= pc_d;
      ram_addr     <= addr_d;
      ram_rd_en    <= rd_d;
      fetch_inst   <= inst_d;
      pc_add_value <= add_d;
      fetch_valid  <= valid_d;
      pc_clear     <= clear_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch.
module tb_if_fetch;

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic        pc_pause;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        ram_ready;
  logic [15:0] ram_data;
  logic        ram_rd_en;
  logic [15:0] ram_addr;
  logic [15:0] fetch_inst;
  logic [15:0] pc_add_value;
  logic        fetch_valid;
  logic        pc_clear;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int total = 0;
  int bad   = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  // Zero-wait-state RAM image: word at addr is addr ^ A5A5.
  assign ram_data = ram_addr ^ 16'hA5A5;

  if_fetch dut (
    .clk_50MHz     (clk_50MHz),
    .rst           (rst),
    .pc_pause      (pc_pause),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .ram_ready     (ram_ready),
    .ram_data      (ram_data),
    .ram_rd_en     (ram_rd_en),
    .ram_addr      (ram_addr),
    .fetch_inst    (fetch_inst),
    .pc_add_value  (pc_add_value),
    .fetch_valid   (fetch_valid),
`ifdef FETCH_TIMEOUT_EN
    .pc_clear      (pc_clear),
    .fetch_err     (fetch_err)
`else
    .pc_clear      (pc_clear)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b0; pc_pause = 1'b0; branch_en = 1'b0; branch_target = 16'h0000; ram_ready = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    check("rst_rd_en", 16'(ram_rd_en), 16'h0000);
    check("rst_addr", ram_addr, 16'h0000);
    check("rst_inst", fetch_inst, 16'h0800);
    check("rst_add", pc_add_value, 16'h0000);
    check("rst_valid", 16'(fetch_valid), 16'h0000);
    check("rst_clear", 16'(pc_clear), 16'h0000);

    rst = 1'b1;
    @(negedge clk_50MHz);
    check("idle_rd_en", 16'(ram_rd_en), 16'h0001);
    check("idle_addr", ram_addr, 16'h0000);
    check("idle_valid", 16'(fetch_valid), 16'h0000);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk_50MHz);
      v = 16'(i);
      check("seq_inst", fetch_inst, v ^ 16'hA5A5);
      check("seq_add", pc_add_value, v + 16'h0001);
      check("seq_valid", 16'(fetch_valid), 16'h0001);
    end
    check("seq_addr", ram_addr, 16'h0004);

    pc_pause = 1'b1;
    @(negedge clk_50MHz);
    check("pause_inst", fetch_inst, 16'hA5A1);
    check("pause_add", pc_add_value, 16'h0005);
    check("pause_rd_en", 16'(ram_rd_en), 16'h0000);
    repeat (2) @(negedge clk_50MHz);
    check("hold_inst", fetch_inst, 16'hA5A1);
    check("hold_add", pc_add_value, 16'h0005);
    check("hold_rd_en", 16'(ram_rd_en), 16'h0000);
    check("hold_addr", ram_addr, 16'h0005);
    pc_pause = 1'b0;
    @(negedge clk_50MHz);
    check("resume_rd_en", 16'(ram_rd_en), 16'h0001);
    check("resume_addr", ram_addr, 16'h0005);
    check("resume_inst", fetch_inst, 16'hA5A1);
    @(negedge clk_50MHz);
    check("resume_cap", fetch_inst, 16'hA5A0);
    check("resume_cap_add", pc_add_value, 16'h0006);

    ram_ready = 1'b0;
    @(negedge clk_50MHz);
    check("wait_valid", 16'(fetch_valid), 16'h0000);
    check("wait_inst", fetch_inst, 16'h0800);
    check("wait_addr", ram_addr, 16'h0006);
    branch_en = 1'b1; branch_target = 16'h0100;
    @(negedge clk_50MHz);
    check("flush_clear", 16'(pc_clear), 16'h0001);
    check("flush_addr", ram_addr, 16'h0006);
    check("flush_rd_en", 16'(ram_rd_en), 16'h0001);
    branch_en = 1'b0;
    @(negedge clk_50MHz);
    check("flush_clear_off", 16'(pc_clear), 16'h0000);
    @(negedge clk_50MHz);
    check("flush_hold_addr", ram_addr, 16'h0006);
    ram_ready = 1'b1;
    @(negedge clk_50MHz);
    check("flush_done_addr", ram_addr, 16'h0100);
    check("flush_discard_valid", 16'(fetch_valid), 16'h0000);
    check("flush_discard_inst", fetch_inst, 16'h0800);
    check("flush_done_clear", 16'(pc_clear), 16'h0000);
    @(negedge clk_50MHz);
    check("target_inst", fetch_inst, 16'hA4A5);
    check("target_add", pc_add_value, 16'h0101);

    branch_en = 1'b1; branch_target = 16'hFFFF;
    @(negedge clk_50MHz);
    check("br_rdy_addr", ram_addr, 16'hFFFF);
    check("br_rdy_clear", 16'(pc_clear), 16'h0001);
    check("br_rdy_valid", 16'(fetch_valid), 16'h0000);
    branch_en = 1'b0;
    @(negedge clk_50MHz);
    check("wrap_inst", fetch_inst, 16'h5A5A);
    check("wrap_add", pc_add_value, 16'h0000);
    check("wrap_addr", ram_addr, 16'h0000);
    @(negedge clk_50MHz);
    check("wrap_next_inst", fetch_inst, 16'hA5A5);
    check("wrap_next_add", pc_add_value, 16'h0001);

    branch_en = 1'b1; branch_target = 16'h0010;
    @(negedge clk_50MHz);
    branch_en = 1'b0; ram_ready = 1'b0;
    @(negedge clk_50MHz);
    check("mid_rd_en", 16'(ram_rd_en), 16'h0001);
    check("mid_addr", ram_addr, 16'h0010);
    #3 rst = 1'b0;
    #1;
    check("async_rd_en", 16'(ram_rd_en), 16'h0000);
    check("async_addr", ram_addr, 16'h0000);
    check("async_inst", fetch_inst, 16'h0800);
    check("async_valid", 16'(fetch_valid), 16'h0000);
    ram_ready = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    rst = 1'b1;
    @(negedge clk_50MHz);
    check("rel_rd_en", 16'(ram_rd_en), 16'h0001);
    check("rel_addr", ram_addr, 16'h0000);
    check("rel_valid", 16'(fetch_valid), 16'h0000);

`ifdef FETCH_TIMEOUT_EN
    ram_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk_50MHz);
    rst = 1'b1;
    @(negedge clk_50MHz);
    repeat (255) @(negedge clk_50MHz);
    check("to_before_err", 16'(fetch_err), 16'h0000);
    check("to_before_valid", 16'(fetch_valid), 16'h0000);
    @(negedge clk_50MHz);
    check("to_err", 16'(fetch_err), 16'h0001);
    check("to_inst", fetch_inst, 16'h0800);
    check("to_valid", 16'(fetch_valid), 16'h0001);
    check("to_add", pc_add_value, 16'h0001);
    check("to_addr", ram_addr, 16'h0001);
    @(negedge clk_50MHz);
    check("to_err_pulse", 16'(fetch_err), 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
